// File: rtl/axil_rdata_fifo.sv
// rtl/axil_rdata_fifo.sv - AXI-Lite read-data FIFO with level output; AXIL_RDATA_ERRCNT_EN enables the error-response counter
module axil_rdata_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              s_RVALID,
    output logic              s_RREADY,
    input  logic [DATA_W-1:0] s_RDATA,
    input  logic [1:0]        s_RRESP,
    output logic              m_RVALID,
    input  logic              m_RREADY,
    output logic [DATA_W-1:0] m_RDATA,
    output logic [1:0]        m_RRESP,
    output logic [LVL_W-1:0]  level,
    input  logic              err_clr,
    output logic [15:0]       err_cnt
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               BEAT_W   = DATA_W + 2;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Each entry carries its response bits alongside the data so they cannot drift apart.
    logic [BEAT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  lvl_q;
    logic [BEAT_W-1:0] head;
    logic              push;
    logic              pop;

    // Ready depends only on stored level and reset, never on m_RREADY, so a full FIFO refuses
    // a beat even when the head is leaving on the same edge.
    assign s_RREADY = (lvl_q != LVL_FULL) && !ARESETn;
    assign m_RVALID = (lvl_q != '0);
    assign push     = s_RVALID && s_RREADY;
    assign pop      = m_RVALID && m_RREADY;
    assign level    = lvl_q;
    assign head     = mem[rd_ptr];

    // Storage array: written on push only; contents are left as-is across reset.
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem[wr_ptr] <= {s_RDATA, s_RRESP};
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); full/empty come from the level count.
    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Level counter: simultaneous push and pop leaves it unchanged.
    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            lvl_q <= '0;
        end else if (push && !pop) begin
            lvl_q <= lvl_q + LVL_ONE;
        end else if (pop && !push) begin
            lvl_q <= lvl_q - LVL_ONE;
        end
    end

    // Head beat is presented only while valid; otherwise the outputs are held at zero.
    always_comb begin
        m_RDATA = '0;
        m_RRESP = '0;
        if (m_RVALID) begin
            m_RDATA = head[BEAT_W-1:2];
            m_RRESP = head[1:0];
        end
    end

`ifdef AXIL_RDATA_ERRCNT_EN
    logic [15:0] err_q;

    // Counts SLVERR/DECERR beats as they leave; clear beats a same-edge increment, count saturates.
    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            err_q <= '0;
        end else if (err_clr) begin
            err_q <= '0;
        end else if (pop && m_RRESP[1] && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_cnt = err_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err_cnt        = '0;
`endif

endmodule

// File: doc/axil_rdata_fifo.md
AXIL_RDATA_FIFO -- requirements
Module: axil_rdata_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, RDATA width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 4, entry count; legal values are powers of 2, minimum 2.
REQ-003 SHALL have parameter LVL_W, default $clog2(DEPTH)+1, width of the level output.
REQ-004 ACLK  in  1  sole clock; all state updates on the rising edge.
REQ-005 ARESETn  in  1  reset, synchronous, active-high (asserted = 1).
REQ-006 s_RVALID  in  1  upstream (slave-side) read data valid.
REQ-007 s_RREADY  out  1  upstream ready; FIFO can accept.
REQ-008 s_RDATA  in  DATA_W  upstream read data.
REQ-009 s_RRESP  in  2  upstream read response.
REQ-010 m_RVALID  out  1  downstream (master-side) valid.
REQ-011 m_RREADY  in  1  downstream ready.
REQ-012 m_RDATA  out  DATA_W  head-of-FIFO data.
REQ-013 m_RRESP  out  2  head-of-FIFO response.
REQ-014 level  out  LVL_W  number of stored entries, 0..DEPTH.
REQ-015 err_clr  in  1  clears the error counter.
REQ-016 err_cnt  out  16  count of error responses delivered downstream.

Function
REQ-017 Push SHALL occur on an edge where s_RVALID=1 and s_RREADY=1; the beat {s_RDATA, s_RRESP} is written at the write pointer.
REQ-018 Pop SHALL occur on an edge where m_RVALID=1 and m_RREADY=1; the read pointer advances.
REQ-019 s_RREADY SHALL equal (level != DEPTH) and ARESETn=0; it has no combinational dependency on m_RREADY, so no push is accepted when full, even with a simultaneous pop.
REQ-020 m_RVALID SHALL equal (level != 0), with no combinational bypass; a push into an empty FIFO at edge N gives m_RVALID=1 after edge N, so latency is 1 cycle.
REQ-021 m_RDATA/m_RRESP SHALL show the head entry while m_RVALID=1 and SHALL be driven 0 while m_RVALID=0.
REQ-022 Once asserted, m_RVALID and the head beat SHALL stay stable until popped; they never drop without a pop.
REQ-023 A simultaneous push and pop SHALL leave level unchanged and move both pointers.
REQ-024 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; full/empty SHALL be derived from level, not from pointer equality.
REQ-025 Beat order SHALL be strict FIFO; RRESP SHALL travel with its own data beat.
REQ-026 level SHALL never exceed DEPTH and never underflow below 0.

Reset
REQ-027 While ARESETn=1 at an edge: pointers = 0, level = 0, err_cnt = 0.
REQ-028 After that edge, m_RVALID = 0, m_RDATA = 0 and m_RRESP = 0.
REQ-029 s_RREADY SHALL be 0 during any cycle with ARESETn=1 and 1 in the first cycle after release.
REQ-030 Reset asserted mid-transfer SHALL discard all stored beats; the array contents need not be cleared.

Configuration
REQ-031 Macro AXIL_RDATA_ERRCNT_EN defined: on each pop with m_RRESP[1]=1 (SLVERR or DECERR), err_cnt SHALL increment by 1 and saturate at 16'hFFFF.
REQ-032 With the macro defined, err_clr=1 at an edge SHALL set err_cnt to 0, and clear wins over a simultaneous increment.
REQ-033 Macro undefined: err_cnt SHALL be tied to 0, err_clr SHALL be ignored, and no counter logic SHALL be present; ports remain in both builds.

Verification
REQ-034 Reset, then one push of 32'hDEAD_BEEF with RRESP=2'b00, m_RREADY=1 -> m_RVALID high exactly 1 cycle after the push with that data; level goes 0 -> 1 -> 0.
REQ-035 DEPTH=4, m_RREADY=0, 5 beats offered -> 4 accepted, s_RREADY=0 while level=4, 5th held; then m_RREADY=1 -> beats exit in order, 5th accepted on the cycle after the first pop.
REQ-036 level=2, push and pop on the same edge -> level stays 2, and the next head is the second-oldest beat.
REQ-037 Stream 10 beats through DEPTH=4 with random m_RREADY backpressure -> all 10 delivered in order, pointers wrap twice, and head is stable while stalled.
REQ-038 AXIL_RDATA_ERRCNT_EN defined: pop RRESP sequence 00, 10, 11, 01 -> err_cnt=2; err_clr=1 -> 0; reset with 3 beats stored -> m_RVALID=0 and level=0 on the next cycle.
